// File: rtl/sort_ctrl_pkg.sv
// Shared types and constants for the selection-sort run controller.
// Holds the controller state encoding, element stride and run-counter sizing.
// No logic lives here beyond a small element-address helper.
package sort_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FETCH   = 3'd3,
    ST_PRESENT = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_e;

  // Byte distance between consecutive 64-bit array elements.
  localparam int unsigned ELEM_STRIDE = 8;

  // Width of the RUN-cycle counter and the value it sticks at.
  localparam int unsigned RUN_CNT_W = 32;
  localparam logic [RUN_CNT_W-1:0] RUN_CNT_SAT = '1;

  // Byte address of element idx relative to the array base.
  function automatic logic [63:0] elem_addr(input logic [63:0] base, input logic [31:0] idx);
    return base + (64'(idx) * 64'(ELEM_STRIDE));
  endfunction

endpackage

// File: rtl/sort_ctrl_watchdog.sv
// Saturating RUN-cycle counter with optional run-length limit compare.
// Latency: counter updates on the edge closing each counted cycle; limit flag is combinational.
// Backpressure: none; counts whenever enabled. Limit compare exists only with SORT_CTRL_WATCHDOG_EN.
module sort_ctrl_watchdog
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_count_en,
  output logic [RUN_CNT_W-1:0] o_run_cycles,
  output logic                 o_limit_hit
);

  logic [RUN_CNT_W-1:0] r_cnt;

  // Count RUN cycles, holding at the saturation value; a new run clears it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count_en && (r_cnt != RUN_CNT_SAT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_run_cycles = r_cnt;

`ifdef SORT_CTRL_WATCHDOG_EN
  // The cycle in which the counter moves to MAX_CYCLES is the last one allowed.
  localparam logic [RUN_CNT_W-1:0] LIMIT_LAST = RUN_CNT_W'(MAX_CYCLES - 1);
  assign o_limit_hit = i_count_en && (r_cnt == LIMIT_LAST);
`else
  localparam int unsigned unused_max_cycles = MAX_CYCLES;
  assign o_limit_hit = 1'b0;
`endif

endmodule

// File: rtl/sort_run_controller.sv
// Sequences one sort run: host load into data memory, core release, halt detect, sorted readback.
// Latency: 1 cycle per load beat, halt seen one edge after the 2nd matching PC, 2 cycles per readback element.
// Backpressure: host_valid gaps stall LOAD; out_ready low holds PRESENT indefinitely. Watchdog via SORT_CTRL_WATCHDOG_EN.
module sort_run_controller
  import sort_ctrl_pkg::*;
#(
  parameter int unsigned N_ELEM     = 8,
  parameter logic [63:0] ELEM_BASE  = 64'h0,
  parameter logic [63:0] HALT_PC    = 64'h0000_0000_0000_0060,
  parameter int unsigned MAX_CYCLES = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_host_valid,
  output logic        o_host_ready,
  input  logic [63:0] i_host_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_out_data,
  output logic        o_core_reset,
  input  logic [63:0] i_core_pc,
  output logic        o_mem_sel,
  output logic [63:0] o_ctl_mem_addr,
  output logic [63:0] o_ctl_mem_wdata,
  output logic        o_ctl_mem_we,
  output logic        o_ctl_mem_re,
  input  logic [63:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [31:0] o_run_cycles
);

  localparam int unsigned IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_out_data;
  logic             r_match_q;

  logic w_idle_like;
  logic w_start_ok;
  logic w_beat;
  logic w_last;
  logic w_match;
  logic w_halt;
  logic w_out_hs;
  logic w_limit;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_start_ok  = i_start && w_idle_like;
  assign w_beat      = (r_state == ST_LOAD) && i_host_valid;
  assign w_last      = (r_idx == IDX_LAST);
  assign w_match     = (i_core_pc == HALT_PC);
  // A halt needs the PC at the self-loop this cycle and the previous RUN cycle.
  assign w_halt      = (r_state == ST_RUN) && w_match && r_match_q;
  assign w_out_hs    = (r_state == ST_PRESENT) && i_out_ready;

  sort_ctrl_watchdog #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (w_start_ok),
    .i_count_en   (r_state == ST_RUN),
    .o_run_cycles (o_run_cycles),
    .o_limit_hit  (w_limit)
  );

  // Next-state selection; halt takes priority over the watchdog limit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_beat && w_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt)       w_state_nxt = ST_FETCH;
        else if (w_limit) w_state_nxt = ST_ERR;
      end
      ST_FETCH: begin
        w_state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (w_out_hs) w_state_nxt = w_last ? ST_DONE : ST_FETCH;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Element index: walks the array during load, and again during readback.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_idx <= '0;
    end else if (w_start_ok) begin
      r_idx <= '0;
    end else if (w_beat) begin
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end else if (w_out_hs && !w_last) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Remember whether the previous RUN cycle saw the halt PC; outside RUN this is cleared,
  // so the first RUN cycle can never complete a match.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_match_q <= 1'b0;
    else          r_match_q <= (r_state == ST_RUN) && w_match;
  end

  // Readback register: loaded in FETCH and held through PRESENT until the handshake.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                r_out_data <= '0;
    else if (r_state == ST_FETCH) r_out_data <= i_mem_rdata;
  end

  assign o_out_data      = r_out_data;
  assign o_host_ready    = (r_state == ST_LOAD);
  assign o_out_valid     = (r_state == ST_PRESENT);
  // The core only runs, and only owns memory, while in RUN.
  assign o_core_reset    = (r_state != ST_RUN);
  assign o_mem_sel       = (r_state != ST_RUN);
  assign o_ctl_mem_we    = w_beat;
  assign o_ctl_mem_re    = (r_state == ST_FETCH);
  assign o_ctl_mem_addr  = ((r_state == ST_LOAD) || (r_state == ST_FETCH))
                           ? elem_addr(ELEM_BASE, 32'(r_idx)) : 64'h0;
  assign o_ctl_mem_wdata = w_beat ? i_host_data : 64'h0;
  assign o_busy          = (r_state == ST_LOAD) || (r_state == ST_RUN) ||
                           (r_state == ST_FETCH) || (r_state == ST_PRESENT);
  assign o_done          = (r_state == ST_DONE);
`ifdef SORT_CTRL_WATCHDOG_EN
  assign o_timeout       = (r_state == ST_ERR);
`else
  assign o_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_sort_run_controller.sv
// Directed bench for sort_run_controller with a behavioural core and data memory.
// The core model walks PC by 4 per cycle and sorts memory just before reaching the halt loop.
// Expected values are hand-derived constants for each directed step.
module tb_sort_run_controller;

  localparam logic [63:0] HALT = 64'h60;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        host_valid;
  logic        host_ready;
  logic [63:0] host_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        core_reset;
  logic [63:0] core_pc;
  logic        mem_sel;
  logic [63:0] ctl_mem_addr;
  logic [63:0] ctl_mem_wdata;
  logic        ctl_mem_we;
  logic        ctl_mem_re;
  logic [63:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;

  int tests = 0;
  int fails = 0;
  int cnt;

  logic [63:0] mem [0:7];
  logic [63:0] load_vals [8];
  logic [63:0] exp_sorted [8];
  int          mode = 0;
  logic [63:0] pc = 64'h0;
  logic        visited = 1'b0;

  always #5 clk = ~clk;

  sort_run_controller #(
    .N_ELEM     (8),
    .ELEM_BASE  (64'h0),
    .HALT_PC    (64'h60),
    .MAX_CYCLES (64)
  ) dut (
    .i_clk           (clk),
    .i_reset         (reset_n),
    .i_start         (start),
    .i_host_valid    (host_valid),
    .o_host_ready    (host_ready),
    .i_host_data     (host_data),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_data      (out_data),
    .o_core_reset    (core_reset),
    .i_core_pc       (core_pc),
    .o_mem_sel       (mem_sel),
    .o_ctl_mem_addr  (ctl_mem_addr),
    .o_ctl_mem_wdata (ctl_mem_wdata),
    .o_ctl_mem_we    (ctl_mem_we),
    .o_ctl_mem_re    (ctl_mem_re),
    .i_mem_rdata     (mem_rdata),
    .o_busy          (busy),
    .o_done          (done),
    .o_timeout       (timeout),
    .o_run_cycles    (run_cycles)
  );

  assign core_pc   = pc;
  assign mem_rdata = mem[ctl_mem_addr[5:3]];

  // Data memory plus behavioural core. Mode 0: run to halt loop. Mode 1: loop forever below HALT.
  // Mode 2: touch HALT for one cycle, step away, then settle on HALT.
  always @(posedge clk) begin
    logic [63:0] t [0:7];
    logic [63:0] sw;
    if (mem_sel && ctl_mem_we) mem[ctl_mem_addr[5:3]] <= ctl_mem_wdata;
    if (core_reset) begin
      pc      <= 64'h0;
      visited <= 1'b0;
    end else if (mode == 1) begin
      pc <= (pc == 64'h5C) ? 64'h0 : pc + 64'd4;
    end else begin
      if (pc == 64'h5C) begin
        for (int i = 0; i < 8; i++) t[i] = mem[i];
        for (int i = 0; i < 8; i++)
          for (int j = 0; j < 7; j++)
            if (t[j] > t[j+1]) begin sw = t[j]; t[j] = t[j+1]; t[j+1] = sw; end
        for (int i = 0; i < 8; i++) mem[i] <= t[i];
      end
      if (pc == HALT && mode == 2 && !visited) begin
        pc      <= 64'h64;
        visited <= 1'b1;
      end else if (pc == 64'h68) begin
        pc <= HALT;
      end else if (pc != HALT) begin
        pc <= pc + 64'd4;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_mem_sel"}, mem_sel, 1);
    check({tag, "_host_ready"}, host_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_run_cycles"}, run_cycles, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_we_re"}, {ctl_mem_we, ctl_mem_re}, 0);
    check({tag, "_addr"}, ctl_mem_addr, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_host_ready", host_ready, 1);
    check("load_busy", busy, 1);
    check("load_run_cycles_clr", run_cycles, 0);
    check("load_done_clr", done, 0);
  endtask

  // Loads load_vals; a start pulse rides along on beat 3 and must be ignored.
  task automatic do_load(input int gap_at);
    for (int i = 0; i < 8; i++) begin
      if (i == gap_at) begin
        host_valid = 1'b0;
        #1;
        check("gap_no_we", ctl_mem_we, 0);
        tick();
      end
      host_valid = 1'b1;
      host_data  = load_vals[i];
      start      = (i == 3);
      #1;
      check("beat_we", ctl_mem_we, 1);
      check("beat_addr", ctl_mem_addr, 64'(i * 8));
      check("beat_wdata", ctl_mem_wdata, load_vals[i]);
      check("beat_core_reset", core_reset, 1);
      tick();
    end
    host_valid = 1'b0;
    start      = 1'b0;
    check("handoff_core_reset", core_reset, 0);
    check("handoff_mem_sel", mem_sel, 0);
    check("handoff_host_ready", host_ready, 0);
    check("mem_last_written", mem[7], load_vals[7]);
  endtask

  // Counts RUN cycles until the core is put back in reset; start pulsed in RUN cycle 3.
  task automatic count_run(output int n, input int bound);
    n = 0;
    while (!core_reset && n < bound) begin
      start = (n == 2);
      n++;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic readback(input int stall_k);
    int n;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!out_valid && n < 10) begin tick(); n++; end
      check("rb_valid", out_valid, 1);
      check("rb_data", out_data, exp_sorted[k]);
      if (k == stall_k) begin
        for (int j = 0; j < 5; j++) begin
          tick();
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_sorted[k]);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("rb_single_beat", out_valid, 0);
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_core_reset", core_reset, 1);
    check("end_mem_sel", mem_sel, 1);
  endtask

  initial begin
    int n;
    reset_n    = 1'b0;
    start      = 1'b0;
    host_valid = 1'b0;
    host_data  = 64'h0;
    out_ready  = 1'b0;
    #12;
    check_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // Run 1: back-to-back load, normal halt after 26 RUN cycles, stall on element 2.
    mode       = 0;
    load_vals  = '{64'd8, 64'd3, 64'd7, 64'd1, 64'd6, 64'd2, 64'd5, 64'd4};
    exp_sorted = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    pulse_start();
    do_load(-1);
    count_run(cnt, 200);
    check("run1_counted", 64'(cnt), 26);
    check("run1_run_cycles", 64'(run_cycles), 26);
    readback(2);

    // Run 2: HALT seen once then left; real halt 4 cycles later. Reset asserted in PRESENT.
    mode = 2;
    pulse_start();
    do_load(4);
    count_run(cnt, 200);
    check("run2_counted", 64'(cnt), 29);
    check("run2_run_cycles", 64'(run_cycles), 29);
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("run2_first", out_data, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_present");
    tick();
    reset_n = 1'b1;
    tick();

    // Run 3: reset asserted partway through RUN.
    mode = 0;
    pulse_start();
    do_load(-1);
    for (int i = 0; i < 5; i++) tick();
    check("run3_in_run", core_reset, 0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_run");
    tick();
    reset_n = 1'b1;
    tick();

    // Run 4: clean reload with new data after the mid-run reset.
    load_vals  = '{64'd40, 64'd10, 64'd30, 64'd20, 64'd80, 64'd70, 64'd60, 64'd50};
    exp_sorted = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd50, 64'd60, 64'd70, 64'd80};
    pulse_start();
    do_load(-1);
    count_run(cnt, 200);
    check("run4_counted", 64'(cnt), 26);
    check("run4_run_cycles", 64'(run_cycles), 26);
    readback(-1);

    // Run 5: program never reaches the halt PC.
    mode = 1;
    pulse_start();
    do_load(-1);
    count_run(cnt, 200);
`ifdef SORT_CTRL_WATCHDOG_EN
    check("wd_counted", 64'(cnt), 64);
    check("wd_run_cycles", 64'(run_cycles), 64);
    check("wd_timeout", timeout, 1);
    check("wd_core_reset", core_reset, 1);
    check("wd_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_no_out_valid", out_valid, 0);
    end
    check("wd_timeout_held", timeout, 1);
`else
    check("nowd_counted", 64'(cnt), 200);
    check("nowd_run_cycles", 64'(run_cycles), 200);
    check("nowd_busy", busy, 1);
    check("nowd_timeout", timeout, 0);
    check("nowd_core_reset", core_reset, 0);
    check("nowd_no_out_valid", out_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sort_run_controller.md
# sort_run_controller

Sequences one selection-sort run on the single-cycle RISC-V core. It loads N_ELEM array elements from a host stream into data memory and releases the core from reset. It then detects the halt loop, streams the sorted elements back out, and arbitrates the data-memory port between itself and the core throughout.

## Interface
- N_ELEM, 8, number of 64-bit array elements
- ELEM_BASE, 64'h0, data-memory byte address of element 0; stride is 8 bytes
- HALT_PC, 64'h0000_0000_0000_0060, PC of the program's terminal self-loop (`beq x0,x0,0`)
- MAX_CYCLES, 4096, watchdog limit in RUN cycles (used only with the macro)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse; begins a run from IDLE, DONE or ERR
- host_valid / host_ready  in / out  1 / 1  load-stream handshake
- host_data  in  64  element to load
- out_valid / out_ready  out / in  1 / 1  readback-stream handshake
- out_data  out  64  sorted element, registered
- core_reset  out  1  active-high reset to the core's PC and register file
- core_pc  in  64  core PC_Out
- mem_sel  out  1  1 = controller owns the data-memory address/wdata/we/re; 0 = core owns them
- ctl_mem_addr  out  64  controller memory address
- ctl_mem_wdata  out  64  controller write data
- ctl_mem_we, ctl_mem_re  out  1  controller write/read strobes
- mem_rdata  in  64  data-memory read data, combinational from address
- busy  out  1  high in LOAD, RUN, FETCH, PRESENT
- done  out  1  level, high in DONE
- timeout  out  1  level, high in ERR
- run_cycles  out  32  RUN cycles of last run, saturating at 32'hFFFF_FFFF

## Operation
- States: IDLE, LOAD, RUN, FETCH, PRESENT, DONE, ERR.
- IDLE/DONE/ERR:
  - On start, go to LOAD.
  - Clear the element index, run_cycles, done and timeout.
  - start in any other state is ignored.
- LOAD:
  - mem_sel=1, core_reset=1, host_ready=1.
  - Each beat (host_valid&&host_ready) drives ctl_mem_we=1, ctl_mem_addr=ELEM_BASE+8*idx, ctl_mem_wdata=host_data in the same cycle, then idx++.
  - After beat N_ELEM-1, go to RUN and reset idx.
- RUN:
  - mem_sel=0, core_reset=0; run_cycles increments each cycle.
  - Halt is core_pc==HALT_PC in two consecutive RUN cycles. On halt, go to FETCH.
  - The first RUN cycle never counts as a halt match.
- FETCH:
  - mem_sel=1, core_reset=1, ctl_mem_re=1, ctl_mem_addr=ELEM_BASE+8*idx.
  - Capture mem_rdata into out_data, then go to PRESENT.
- PRESENT:
  - out_valid=1; out_data is held stable until out_ready.
  - On the handshake: if idx==N_ELEM-1, go to DONE; else idx++ and go to FETCH.
- DONE: done=1, core_reset=1, mem_sel=1.
- ERR: timeout=1, core_reset=1, mem_sel=1, no readback.
- host_ready=0 outside LOAD. out_valid=0 outside PRESENT. ctl_mem_we is high only on LOAD beats.

## Timing
- Reset values: state IDLE, core_reset=1, mem_sel=1, all other outputs 0, out_data=0, run_cycles=0.
- Reset asserted mid-run: immediate return to reset values. Memory contents are not restored.
- Load: N_ELEM accepted beats, one write per beat. Back-to-back beats allowed; host_valid gaps stall.
- Handoff: core_reset falls in the first RUN cycle. The core's first instruction executes that cycle.
- Halt detect: FETCH is entered one edge after the second matching cycle.
- Readback: 2 cycles per element minimum (FETCH+PRESENT). out_ready held low stalls indefinitely.
- Best-case total: N_ELEM + run + 2*N_ELEM cycles.

## Configuration
- SORT_CTRL_WATCHDOG_EN defined:
  - In RUN, when run_cycles reaches MAX_CYCLES without halt, go to ERR.
  - A halt and the limit in the same cycle: halt wins.
- Undefined: RUN waits for halt forever, timeout tied 0, ERR unreachable.

## Structure
- Package sort_ctrl_pkg holds:
  - the state enum;
  - ELEM_STRIDE=8;
  - run_cycles width and saturation constant.
- Sub-module sort_ctrl_watchdog holds the saturating run_cycles counter and the limit compare. Its limit compare is instantiated only under the macro.

## Test plan
- Load 8,3,7,1,6,2,5,4 with back-to-back host_valid: 8 writes to addresses 0x00..0x38, core_reset falls on the next cycle.
- After RUN with a sorting program: out stream is 1..8 in order; done=1 after the 8th handshake; run_cycles equals counted RUN cycles.
- Hold out_ready=0 for 5 cycles in PRESENT: out_valid stays 1 and out_data is unchanged; a single beat transfers when ready rises.
- Program never reaching HALT_PC, macro on, MAX_CYCLES=64: ERR after 64 RUN cycles, timeout=1, core_reset=1, no out_valid. Same with macro off: stays in RUN.
- Assert reset in RUN and in PRESENT: outputs return to reset values asynchronously; start then reloads cleanly.
- Pulse start during LOAD and RUN: ignored. core_pc==HALT_PC for a single cycle only: no halt detected.
